hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the decode stage and inspects the instruction held in IF/ID. It keeps a 3-entry scoreboard of in-flight register writers (EX, MEM, WB). From that it drives the PC/IF-ID write enables, the ID/EX bubble and the branch flushes, and it maintains stall and flush statistics.

## Interface
- CNT_W, 16: width of the saturating statistic counters.
- STALL_MAX, 3: maximum number of consecutive stall cycles before the deadlock flag is raised.

- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_data_Instr  in  32  instruction currently in IF/ID
- i_con_mem_branch_taken  in  1  branch in MEM resolved taken this cycle
- i_con_hold  in  1  external freeze (memory wait)
- o_con_pc_wr  out  1  PC write enable
- o_con_ifid_wr  out  1  IF/ID write enable
- o_con_idex_bubble  out  1  decode loads all-zero controls into ID/EX
- o_con_flush_ifid  out  1  clear IF/ID
- o_con_flush_idex  out  1  clear ID/EX
- o_con_flush_exmem  out  1  clear EX/MEM
- o_stat_stall  out  CNT_W  count of stall cycles
- o_stat_flush  out  CNT_W  count of taken-branch flushes
- o_err_deadlock  out  1  sticky: stall run exceeded STALL_MAX

## Operation
- **Decode of the IF/ID instruction (opcode = [31:26]):**
  - R-type 000000: reads rs and rt; writes rd [15:11].
  - lw 100011: reads rs; writes rt; is a load.
  - sw 101011: reads rs and rt; no write.
  - beq 000100: reads rs and rt; no write.
  - All other opcodes: no reads, no write.
  - A destination of $0 is never recorded.
- **Scoreboard entries:** each of EX, MEM and WB holds {valid, dest[4:0], load}.
- **Hazard rule with FORWARD_EN:** hazard = EX.valid & EX.load & EX.dest matches a read source of the ID instruction.
- **Hazard rule without FORWARD_EN:** hazard = any valid entry in EX, MEM or WB matches a read source. The register bank does not bypass same-cycle writes, so the WB entry counts.
- **Stall:** o_con_pc_wr = 0, o_con_ifid_wr = 0, o_con_idex_bubble = 1.
- **Taken branch:** all three flush outputs = 1, and the stall is suppressed, since the stalled instruction is discarded anyway.
- **Hold:** pc_wr = 0 and ifid_wr = 0; bubble and flush = 0; scoreboard, counters and FSM are all frozen.
- **Priority:** hold > branch > hazard > run.
- **Scoreboard advance** (every cycle without hold):
  - WB <= MEM.
  - MEM <= EX, except that on a taken branch MEM is invalidated (the EX instruction is flushed).
  - EX <= ID writer if the cycle is neither stall nor branch; otherwise invalid.
- **FSM** (RUN, STALL):
  - RUN -> STALL on hazard (without hold or branch).
  - STALL -> RUN when the hazard clears or a branch is taken.
  - The run counter increments each STALL cycle.
  - o_err_deadlock sets when the counter exceeds STALL_MAX; it is cleared only by reset.
- **Counters:** o_stat_stall +1 per stall cycle; o_stat_flush +1 per taken-branch cycle. Both saturate at all-ones and do not wrap.

## Timing
- All hazard, flush and enable outputs are combinational from scoreboard registers and current inputs; there is zero latency to the consuming pipeline registers.
- Scoreboard, FSM and counters update on the rising edge of i_clk.
- A load-use hazard costs exactly 1 stall cycle with FORWARD_EN.
- Without FORWARD_EN, a dependency costs up to 3 stall cycles (producer in EX → 3, MEM → 2, WB → 1).
- Reset values (while i_rst_n low): scoreboard invalid, FSM RUN, counters 0, o_err_deadlock 0.
- Outputs forced during reset: pc_wr 0, ifid_wr 0, bubble 0, flushes 0.
- The cycle after deassertion behaves as RUN with an empty scoreboard.
- Reset mid-stall discards all state; there is no stall after release.

## Configuration
- **FORWARD_EN defined:** the EX stage has full forwarding; only load-use produces a stall.
- **FORWARD_EN undefined:** there is no forwarding; stall on any RAW match in EX, MEM or WB.
- STALL_MAX applies in both modes. With the default of 3, the deadlock flag stays clear in correct operation.

## Test plan
- **Load-use stall (FORWARD_EN):** issue lw $2,0($1), then add $3,$2,$4 in IF/ID -> exactly 1 cycle of pc_wr = 0, ifid_wr = 0, bubble = 1; o_stat_stall = 1; then add proceeds.
- **RAW stall (no FORWARD_EN):** issue add $2,$1,$1, then add $5,$2,$2 -> 3 consecutive stall cycles; o_stat_stall = 3; o_err_deadlock stays 0.
- **$0 writer:** issue lw $0, then add $3,$0,$0 -> no stall in either mode.
- **Branch during hazard:** taken branch in the same cycle as a load-use hazard -> all three flushes = 1, bubble = 0, pc_wr = 1; o_stat_flush = 1; the EX entry is invalidated, so no stall next cycle.
- **Hold mid-stall:** hold asserted for 4 cycles during a stall -> pc_wr = 0 and counters unchanged throughout; the stall resumes with the same remaining length after hold drops.
- **Reset and deadlock:** with STALL_MAX = 0, a single stall sets o_err_deadlock. Asserting reset mid-stall then gives: o_err_deadlock = 0, counters = 0, no stall after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// It decodes the IF/ID instruction and keeps a 3-entry scoreboard of in-flight
// register writers (EX, MEM, WB). From these it drives the PC/IF-ID write
// enables, the ID/EX bubble and the branch flushes. It also keeps saturating
// stall/flush statistics and a sticky flag for stall runs that are too long.
//
// Build option:
//   FORWARD_EN  defined   -> the EX stage forwards; only load-use stalls.
//               undefined -> no forwarding; stall on any RAW match in EX/MEM/WB.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_data_Instr             instruction currently held in IF/ID
//   i_con_mem_branch_taken   branch in MEM resolved taken this cycle
//   i_con_hold               external freeze (memory wait)
//   o_con_pc_wr              PC write enable            (combinational)
//   o_con_ifid_wr            IF/ID write enable         (combinational)
//   o_con_idex_bubble        zero controls into ID/EX   (combinational)
//   o_con_flush_ifid/idex/exmem  branch flushes         (combinational)
//   o_stat_stall             saturating stall-cycle count
//   o_stat_flush             saturating taken-branch count
//   o_err_deadlock           sticky: stall run longer than STALL_MAX
module hazard_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned STALL_MAX = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_data_Instr,
    input  logic             i_con_mem_branch_taken,
    input  logic             i_con_hold,
    output logic             o_con_pc_wr,
    output logic             o_con_ifid_wr,
    output logic             o_con_idex_bubble,
    output logic             o_con_flush_ifid,
    output logic             o_con_flush_idex,
    output logic             o_con_flush_exmem,
    output logic [CNT_W-1:0] o_stat_stall,
    output logic [CNT_W-1:0] o_stat_flush,
    output logic             o_err_deadlock
);

    // Run counter only has to reach STALL_MAX + 1.
    localparam int unsigned RUN_W = $clog2(STALL_MAX + 2);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

`ifdef FORWARD_EN
    localparam bit LOAD_ONLY  = 1'b1;  // EX hits matter only for loads
    localparam bit CHECK_LATE = 1'b0;  // MEM/WB are covered by forwarding
`else
    localparam bit LOAD_ONLY  = 1'b0;
    localparam bit CHECK_LATE = 1'b1;  // register bank does not bypass WB
`endif

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       load;
    } sb_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_t;

    sb_entry_t sb_ex, sb_mem, sb_wb, id_wr;
    state_t    state;
    logic [RUN_W-1:0] run_cnt, run_base, run_next;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic       reads_rs, reads_rt;
    logic       hazard, branch, stall_c, run_over;
    logic       unused_instr_bits;

    assign opcode = i_data_Instr[31:26];
    assign rs     = i_data_Instr[25:21];
    assign rt     = i_data_Instr[20:16];
    assign rd     = i_data_Instr[15:11];
    assign unused_instr_bits = ^i_data_Instr[10:0];

    // Source/destination decode of the IF/ID instruction.
    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        id_wr    = '0;
        unique case (opcode)
            OP_RTYPE: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                id_wr    = '{valid: (rd != 5'd0), dest: rd, load: 1'b0};
            end
            OP_LW: begin
                reads_rs = 1'b1;
                id_wr    = '{valid: (rt != 5'd0), dest: rt, load: 1'b1};
            end
            OP_SW, OP_BEQ: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // True when a scoreboard entry produces a register the ID instruction reads.
    function automatic logic src_hit(input sb_entry_t e, input logic load_only,
                                     input logic use_rs, input logic [4:0] src_s,
                                     input logic use_rt, input logic [4:0] src_t);
        return e.valid && (e.load || !load_only) &&
               ((use_rs && (e.dest == src_s)) || (use_rt && (e.dest == src_t)));
    endfunction

    always_comb begin
        hazard = src_hit(sb_ex, LOAD_ONLY, reads_rs, rs, reads_rt, rt) ||
                 (CHECK_LATE &&
                  (src_hit(sb_mem, 1'b0, reads_rs, rs, reads_rt, rt) ||
                   src_hit(sb_wb,  1'b0, reads_rs, rs, reads_rt, rt)));
    end

    // Priority: hold > branch > hazard > run.
    assign branch  = !i_con_hold && i_con_mem_branch_taken;
    assign stall_c = !i_con_hold && !i_con_mem_branch_taken && hazard;

    assign o_con_pc_wr       = i_rst_n && !i_con_hold && !stall_c;
    assign o_con_ifid_wr     = i_rst_n && !i_con_hold && !stall_c;
    assign o_con_idex_bubble = i_rst_n && stall_c;
    assign o_con_flush_ifid  = i_rst_n && branch;
    assign o_con_flush_idex  = i_rst_n && branch;
    assign o_con_flush_exmem = i_rst_n && branch;

    // Scoreboard shift; a taken branch kills the EX instruction and the ID one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else if (!i_con_hold) begin
            sb_wb  <= sb_mem;
            sb_mem <= branch ? '0 : sb_ex;
            sb_ex  <= (stall_c || branch) ? '0 : id_wr;
        end
    end

    // A run continues only from STALL; entering from RUN starts at one.
    assign run_base = (state == ST_STALL) ? run_cnt : '0;
    assign run_next = (run_base == '1) ? run_base : run_base + RUN_W'(1);
    assign run_over = (32'(run_base) + 32'd1) > STALL_MAX;

    // RUN/STALL tracking, deadlock flag and statistics.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_RUN;
            run_cnt        <= '0;
            o_err_deadlock <= 1'b0;
            o_stat_stall   <= '0;
            o_stat_flush   <= '0;
        end else if (!i_con_hold) begin
            state   <= stall_c ? ST_STALL : ST_RUN;
            run_cnt <= stall_c ? run_next : '0;
            if (stall_c && run_over) begin
                o_err_deadlock <= 1'b1;
            end
            if (stall_c && (o_stat_stall != '1)) begin
                o_stat_stall <= o_stat_stall + CNT_W'(1);
            end
            if (branch && (o_stat_flush != '1)) begin
                o_stat_flush <= o_stat_flush + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of directed per-cycle vectors
// followed by hand-written saturation and reset-mid-stall sequences. A second
// instance with STALL_MAX = 0 and 4-bit counters shares the stimulus.
module tb_hazard_ctrl;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT0_W = 4;

    typedef struct {
        logic [31:0] instr;
        logic        br;
        logic        hold;
        logic        pc_wr;
        logic        bubble;
        logic        flush;
        int          stall_cnt;
        int          flush_cnt;
        logic        dl0;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] instr;
    logic br, hold;

    logic pc_wr, ifid_wr, bubble, fl_ifid, fl_idex, fl_exmem, err;
    logic [CNT_W-1:0] st_stall, st_flush;
    logic pc_wr0, ifid_wr0, bubble0, fl_ifid0, fl_idex0, fl_exmem0, err0;
    logic [CNT0_W-1:0] st_stall0, st_flush0;
    logic [5:0] ctl;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    assign ctl = {pc_wr, ifid_wr, bubble, fl_ifid, fl_idex, fl_exmem};

    hazard_ctrl #(.CNT_W(CNT_W), .STALL_MAX(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_Instr(instr),
        .i_con_mem_branch_taken(br), .i_con_hold(hold),
        .o_con_pc_wr(pc_wr), .o_con_ifid_wr(ifid_wr), .o_con_idex_bubble(bubble),
        .o_con_flush_ifid(fl_ifid), .o_con_flush_idex(fl_idex),
        .o_con_flush_exmem(fl_exmem), .o_stat_stall(st_stall),
        .o_stat_flush(st_flush), .o_err_deadlock(err)
    );

    hazard_ctrl #(.CNT_W(CNT0_W), .STALL_MAX(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_Instr(instr),
        .i_con_mem_branch_taken(br), .i_con_hold(hold),
        .o_con_pc_wr(pc_wr0), .o_con_ifid_wr(ifid_wr0), .o_con_idex_bubble(bubble0),
        .o_con_flush_ifid(fl_ifid0), .o_con_flush_idex(fl_idex0),
        .o_con_flush_exmem(fl_exmem0), .o_stat_stall(st_stall0),
        .o_stat_flush(st_flush0), .o_err_deadlock(err0)
    );

    function automatic logic [31:0] op_add(input int rd, input int rs, input int rt);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction
    function automatic logic [31:0] op_lw(input int rt, input int rs);
        return {6'b100011, 5'(rs), 5'(rt), 16'h0000};
    endfunction
    function automatic logic [31:0] op_sw(input int rt, input int rs);
        return {6'b101011, 5'(rs), 5'(rt), 16'h0000};
    endfunction
    function automatic logic [31:0] op_beq(input int rs, input int rt);
        return {6'b000100, 5'(rs), 5'(rt), 16'h0004};
    endfunction
    function automatic logic [31:0] op_addi(input int rt, input int rs);
        return {6'b001000, 5'(rs), 5'(rt), 16'h0001};
    endfunction

    function automatic logic [5:0] exp_ctl(input logic pw, input logic bb, input logic fl);
        return {pw, pw, bb, fl, fl, fl};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic add_vec(input logic [31:0] ins, input logic b, input logic h,
                           input logic pw, input logic bb, input logic fl,
                           input int st, input int flc, input logic d0);
        vec_t v;
        v.instr = ins; v.br = b; v.hold = h;
        v.pc_wr = pw; v.bubble = bb; v.flush = fl;
        v.stall_cnt = st; v.flush_cnt = flc; v.dl0 = d0;
        vecs.push_back(v);
    endtask

    task automatic step(input logic [31:0] ins, input logic b, input logic h);
        @(posedge clk);
        #1;
        instr = ins;
        br    = b;
        hold  = h;
    endtask

    initial begin
        int s_len;
        int base_st;
        int base_fl;

        rst_n = 1'b0;
        instr = op_add(3, 2, 2);
        br    = 1'b1;
        hold  = 1'b0;

        // Vectors: instr, br, hold | pc_wr, bubble, flush | stall, flush counts, dl0
`ifdef FORWARD_EN
        add_vec(op_lw(2, 1),      0, 0, 1, 0, 0, 0, 0, 0);
        add_vec(op_add(3, 2, 4),  0, 0, 0, 1, 0, 0, 0, 0);
        add_vec(op_add(3, 2, 4),  0, 0, 1, 0, 0, 1, 0, 1);
        add_vec(op_lw(0, 1),      0, 0, 1, 0, 0, 1, 0, 1);
        add_vec(op_add(3, 0, 0),  0, 0, 1, 0, 0, 1, 0, 1);
        add_vec(op_lw(7, 1),      0, 0, 1, 0, 0, 1, 0, 1);
        add_vec(op_add(8, 7, 0),  1, 0, 1, 0, 1, 1, 0, 1);
        add_vec(op_add(8, 7, 0),  0, 0, 1, 0, 0, 1, 1, 1);
        add_vec(op_add(9, 8, 8),  0, 0, 1, 0, 0, 1, 1, 1);
        add_vec(op_lw(10, 1),     0, 0, 1, 0, 0, 1, 1, 1);
        for (int k = 0; k < 4; k++)
            add_vec(op_add(11, 10, 10), 0, 1, 0, 0, 0, 1, 1, 1);
        add_vec(op_add(11, 10, 10), 0, 0, 0, 1, 0, 1, 1, 1);
        add_vec(op_add(11, 10, 10), 0, 0, 1, 0, 0, 2, 1, 1);
        add_vec(32'h0,            1, 1, 0, 0, 0, 2, 1, 1);
        add_vec(32'h0,            0, 0, 1, 0, 0, 2, 1, 1);
        add_vec(op_sw(4, 11),     0, 0, 1, 0, 0, 2, 1, 1);
        add_vec(op_lw(4, 1),      0, 0, 1, 0, 0, 2, 1, 1);
        add_vec(op_beq(4, 0),     0, 0, 0, 1, 0, 2, 1, 1);
        add_vec(op_beq(4, 0),     0, 0, 1, 0, 0, 3, 1, 1);
        add_vec(op_lw(12, 1),     0, 0, 1, 0, 0, 3, 1, 1);
        add_vec(op_addi(12, 12),  0, 0, 1, 0, 0, 3, 1, 1);
`else
        add_vec(op_add(2, 1, 1),  0, 0, 1, 0, 0, 0, 0, 0);
        add_vec(op_add(5, 2, 2),  0, 0, 0, 1, 0, 0, 0, 0);
        add_vec(op_add(5, 2, 2),  0, 0, 0, 1, 0, 1, 0, 1);
        add_vec(op_add(5, 2, 2),  0, 0, 0, 1, 0, 2, 0, 1);
        add_vec(op_add(5, 2, 2),  0, 0, 1, 0, 0, 3, 0, 1);
        add_vec(op_lw(0, 1),      0, 0, 1, 0, 0, 3, 0, 1);
        add_vec(op_add(3, 0, 0),  0, 0, 1, 0, 0, 3, 0, 1);
        add_vec(op_add(7, 1, 1),  0, 0, 1, 0, 0, 3, 0, 1);
        add_vec(op_add(8, 7, 0),  1, 0, 1, 0, 1, 3, 0, 1);
        add_vec(op_add(8, 7, 0),  0, 0, 1, 0, 0, 3, 1, 1);
        add_vec(op_add(9, 8, 8),  0, 0, 0, 1, 0, 3, 1, 1);
        for (int k = 0; k < 4; k++)
            add_vec(op_add(9, 8, 8), 0, 1, 0, 0, 0, 4, 1, 1);
        add_vec(op_add(9, 8, 8),  0, 0, 0, 1, 0, 4, 1, 1);
        add_vec(op_add(9, 8, 8),  0, 0, 0, 1, 0, 5, 1, 1);
        add_vec(op_add(9, 8, 8),  0, 0, 1, 0, 0, 6, 1, 1);
        add_vec(32'h0,            1, 1, 0, 0, 0, 6, 1, 1);
        add_vec(32'h0,            0, 0, 1, 0, 0, 6, 1, 1);
        add_vec(op_lw(10, 1),     0, 0, 1, 0, 0, 6, 1, 1);
        add_vec(op_sw(4, 10),     0, 0, 0, 1, 0, 6, 1, 1);
        add_vec(op_sw(4, 10),     0, 0, 0, 1, 0, 7, 1, 1);
        add_vec(op_sw(4, 10),     0, 0, 0, 1, 0, 8, 1, 1);
        add_vec(op_sw(4, 10),     0, 0, 1, 0, 0, 9, 1, 1);
        add_vec(op_add(4, 1, 1),  0, 0, 1, 0, 0, 9, 1, 1);
        add_vec(op_beq(4, 0),     0, 0, 0, 1, 0, 9, 1, 1);
        add_vec(op_beq(4, 0),     0, 0, 0, 1, 0, 10, 1, 1);
        add_vec(op_beq(4, 0),     0, 0, 0, 1, 0, 11, 1, 1);
        add_vec(op_beq(4, 0),     0, 0, 1, 0, 0, 12, 1, 1);
        add_vec(op_add(12, 1, 1), 0, 0, 1, 0, 0, 12, 1, 1);
        add_vec(op_addi(12, 12),  0, 0, 1, 0, 0, 12, 1, 1);
`endif

        // Reset state, with a would-be hazard and a taken branch on the inputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ctl", 32'(ctl), 32'(6'b000000));
        check("reset stall cnt", 32'(st_stall), 32'd0);
        check("reset flush cnt", 32'(st_flush), 32'd0);
        check("reset deadlock", 32'(err), 32'd0);
        rst_n = 1'b1;
        br    = 1'b0;
        instr = 32'h0;

        foreach (vecs[i]) begin
            step(vecs[i].instr, vecs[i].br, vecs[i].hold);
            @(negedge clk);
            check($sformatf("v%0d ctl", i), 32'(ctl),
                  32'(exp_ctl(vecs[i].pc_wr, vecs[i].bubble, vecs[i].flush)));
            check($sformatf("v%0d stall cnt", i), 32'(st_stall), 32'(vecs[i].stall_cnt));
            check($sformatf("v%0d flush cnt", i), 32'(st_flush), 32'(vecs[i].flush_cnt));
            check($sformatf("v%0d deadlock", i), 32'(err), 32'd0);
            check($sformatf("v%0d deadlock max0", i), 32'(err0), 32'(vecs[i].dl0));
        end

        // Counter saturation on the 4-bit instance; the 16-bit one keeps counting.
        s_len   = FWD ? 1 : 3;
        base_st = vecs[vecs.size()-1].stall_cnt;
        base_fl = vecs[vecs.size()-1].flush_cnt;
        for (int k = 0; k < 20; k++) begin
            step(op_lw(2, 1), 1'b0, 1'b0);
            for (int j = 0; j <= s_len; j++) step(op_add(3, 2, 2), 1'b0, 1'b0);
        end
        @(negedge clk);
        check("sat run after stalls", 32'(ctl), 32'(exp_ctl(1'b1, 1'b0, 1'b0)));
        check("sat stall cnt", 32'(st_stall), 32'(base_st + 20 * s_len));
        check("sat stall cnt w4", 32'(st_stall0), 32'd15);
        for (int k = 0; k < 20; k++) step(32'h0, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("sat flush cnt", 32'(st_flush), 32'(base_fl + 20));
        check("sat flush cnt w4", 32'(st_flush0), 32'd15);
        check("sat deadlock", 32'(err), 32'd0);

        // Reset in the middle of a stall discards all state.
        step(op_lw(13, 1), 1'b0, 1'b0);
        step(op_add(14, 13, 13), 1'b0, 1'b0);
        @(negedge clk);
        check("pre-reset stall", 32'(ctl), 32'(exp_ctl(1'b0, 1'b1, 1'b0)));
        rst_n = 1'b0;
        br    = 1'b1;
        #1;
        check("mid reset ctl", 32'(ctl), 32'(6'b000000));
        check("mid reset stall cnt", 32'(st_stall), 32'd0);
        check("mid reset flush cnt", 32'(st_flush), 32'd0);
        check("mid reset deadlock max0", 32'(err0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        br    = 1'b0;
        #1;
        check("post reset no stall", 32'(ctl), 32'(exp_ctl(1'b1, 1'b0, 1'b0)));
        @(posedge clk);
        @(negedge clk);
        check("post reset run", 32'(ctl), 32'(exp_ctl(1'b1, 1'b0, 1'b0)));
        check("post reset stall cnt", 32'(st_stall), 32'd0);
        check("post reset deadlock max0", 32'(err0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
